// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 4x4 multiplier among NREQ requesters.
// A tag pipeline matched to the multiplier latency routes each product back to its owner.
module mult_share_arbiter #(
    parameter  int NREQ        = 4,
    parameter  int MUL_LATENCY = 4,
    localparam int IDW         = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [3:0]        mul_a,
    output logic [3:0]        mul_b,
    input  logic [7:0]        mul_product,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_product,
    output logic              busy
);

    logic [IDW-1:0]         last_q, last_d;
    logic [IDW-1:0]         gnt_id;
    logic                   hit;
    logic [MUL_LATENCY-1:0] vld_q, vld_d;
    logic [IDW-1:0]         id_q [MUL_LATENCY];

    // Priority starts one past the last grant and wraps, so every requester waits at most NREQ-1 grants.
    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        hit       = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            int idx;
            idx = (int'(last_q) + off) % NREQ;
            if (!hit && req_valid[idx]) begin
                hit            = 1'b1;
                req_ready[idx] = 1'b1;
                gnt_id         = IDW'(idx);
            end
        end
    end

    always_comb begin
        mul_a = 4'd0;
        mul_b = 4'd0;
        if (hit) begin
            mul_a = req_a[{gnt_id, 2'b00} +: 4];
            mul_b = req_b[{gnt_id, 2'b00} +: 4];
        end
    end

    always_comb begin
        last_d = hit ? gnt_id : last_q;
        vld_d  = {vld_q[MUL_LATENCY-2:0], hit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NREQ - 1);
            vld_q  <= '0;
            for (int j = 0; j < MUL_LATENCY; j++) id_q[j] <= '0;
        end else begin
            last_q  <= last_d;
            vld_q   <= vld_d;
            id_q[0] <= gnt_id;
            for (int j = 1; j < MUL_LATENCY; j++) id_q[j] <= id_q[j-1];
        end
    end

    // The multiplier is never reset, so stale products are masked by the tag valid.
    always_comb begin
        rsp_valid   = vld_q[MUL_LATENCY-1];
        rsp_id      = id_q[MUL_LATENCY-1];
        rsp_product = rsp_valid ? mul_product : 8'd0;
        busy        = |vld_q;
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural 4-stage multiplier.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic [3:0]        mul_a, mul_b;
    logic [7:0]        mul_product;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [7:0]        rsp_product;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [NREQ-1:0] keep = '0;

    int rid_q[$];
    int rp_q[$];
    int rc_q[$];
    int gnt_q[$];

    logic [7:0] mp_q [LAT];

    mult_share_arbiter #(.NREQ(NREQ), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mp_q[0] <= {4'b0, mul_a} * {4'b0, mul_b};
        for (int j = 1; j < LAT; j++) mp_q[j] <= mp_q[j-1];
    end
    assign mul_product = mp_q[LAT-1];

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rid_q.push_back(int'(rsp_id));
            rp_q.push_back(int'(rsp_product));
            rc_q.push_back(cyc);
        end
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) gnt_q.push_back(i);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    // Requesters drop valid after acceptance unless held by keep.
    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = (req_valid & ~acc) | keep;
    endtask

    task automatic clear_logs();
        rid_q.delete();
        rp_q.delete();
        rc_q.delete();
        gnt_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset values and combinational grant during reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_busy", busy, 0);
        req_valid = 4'b0100;
        #1 chk("rst_ready_comb", req_ready, 4'b0100);
        @(posedge clk);
        #1 chk("rst_no_accept", busy, 0);
        req_valid = '0;
        rst_n = 1'b1;

        // Single request, latency
        set_op(0, 4'd3, 4'd5);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        chk("single_mul_a", mul_a, 3);
        chk("single_mul_b", mul_b, 5);
        step();
        #1;
        chk("single_bubble_a", mul_a, 0);
        chk("single_busy", busy, 1);
        step();
        step();
        chk("single_early", rsp_valid, 0);
        step();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_product", rsp_product, 15);
        step();
        chk("single_rsp_drop", rsp_valid, 0);
        chk("single_busy_fall", busy, 0);

        // All four from reset
        do_reset();
        set_op(0, 4'd3, 4'd5);
        set_op(1, 4'd7, 4'd2);
        set_op(2, 4'd8, 4'd9);
        set_op(3, 4'd15, 4'd15);
        clear_logs();
        req_valid = 4'b1111;
        repeat (8) step();
        chk("all_n_gnt", gnt_q.size(), 4);
        chk("all_n_rsp", rid_q.size(), 4);
        if (gnt_q.size() == 4 && rid_q.size() == 4) begin
            chk("all_gnt0", gnt_q[0], 0);
            chk("all_gnt1", gnt_q[1], 1);
            chk("all_gnt2", gnt_q[2], 2);
            chk("all_gnt3", gnt_q[3], 3);
            chk("all_id0", rid_q[0], 0);
            chk("all_p0", rp_q[0], 15);
            chk("all_id1", rid_q[1], 1);
            chk("all_p1", rp_q[1], 14);
            chk("all_id2", rid_q[2], 2);
            chk("all_p2", rp_q[2], 72);
            chk("all_id3", rid_q[3], 3);
            chk("all_p3", rp_q[3], 225);
            chk("all_consec1", rc_q[1] - rc_q[0], 1);
            chk("all_consec3", rc_q[3] - rc_q[2], 1);
        end

        // Fairness between requesters 1 and 3 (last = 3 here)
        set_op(1, 4'd1, 4'd1);
        set_op(3, 4'd2, 4'd2);
        clear_logs();
        keep = 4'b1010;
        req_valid = 4'b1010;
        repeat (4) step();
        keep = '0;
        req_valid = '0;
        repeat (5) step();
        chk("fair_n_gnt", gnt_q.size(), 4);
        if (gnt_q.size() == 4) begin
            chk("fair_gnt0", gnt_q[0], 1);
            chk("fair_gnt1", gnt_q[1], 3);
            chk("fair_gnt2", gnt_q[2], 1);
            chk("fair_gnt3", gnt_q[3], 3);
        end

        // Hold: requester 2 waits while requester 1 is granted
        set_op(1, 4'd2, 4'd3);
        set_op(2, 4'd6, 4'd4);
        clear_logs();
        req_valid = 4'b0110;
        #1;
        chk("hold_ready1", req_ready, 4'b0010);
        chk("hold_mul_a1", mul_a, 2);
        chk("hold_mul_b1", mul_b, 3);
        step();
        #1;
        chk("hold_ready2", req_ready, 4'b0100);
        chk("hold_mul_a2", mul_a, 6);
        chk("hold_mul_b2", mul_b, 4);
        step();
        repeat (5) step();
        chk("hold_n_rsp", rid_q.size(), 2);
        if (rid_q.size() == 2) begin
            chk("hold_id0", rid_q[0], 1);
            chk("hold_p0", rp_q[0], 6);
            chk("hold_id1", rid_q[1], 2);
            chk("hold_p1", rp_q[1], 24);
        end

        // Reset with two operations in flight
        set_op(0, 4'd5, 4'd5);
        set_op(1, 4'd4, 4'd4);
        clear_logs();
        req_valid = 4'b0011;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) step();
        chk("midrst_gnt_before", gnt_q.size(), 2);
        chk("midrst_no_rsp", rid_q.size(), 0);
        chk("midrst_product", rsp_product, 0);
        chk("midrst_busy_after", busy, 0);
        req_valid = 4'b1111;
        #1 chk("midrst_prio0", req_ready, 4'b0001);
        req_valid = '0;
        #1;

        // Bubbles: requests on alternate cycles
        set_op(2, 4'd9, 4'd9);
        set_op(3, 4'd10, 4'd3);
        set_op(0, 4'd1, 4'd7);
        clear_logs();
        req_valid = 4'b0100;
        #1 chk("bub_ready_r2", req_ready, 4'b0100);
        step();
        #1 chk("bub_idle_a0", {mul_a, mul_b}, 0);
        step();
        req_valid = 4'b1000;
        #1 chk("bub_ready_r3", req_ready, 4'b1000);
        step();
        #1 chk("bub_idle_a1", {mul_a, mul_b}, 0);
        step();
        req_valid = 4'b0001;
        #1 chk("bub_ready_r0", req_ready, 4'b0001);
        step();
        #1 chk("bub_idle_ready", req_ready, 0);
        repeat (6) step();
        chk("bub_n_rsp", rid_q.size(), 3);
        if (rid_q.size() == 3) begin
            chk("bub_id0", rid_q[0], 2);
            chk("bub_p0", rp_q[0], 81);
            chk("bub_id1", rid_q[1], 3);
            chk("bub_p1", rp_q[1], 30);
            chk("bub_id2", rid_q[2], 0);
            chk("bub_p2", rp_q[2], 7);
            chk("bub_gap0", rc_q[1] - rc_q[0], 2);
            chk("bub_gap1", rc_q[2] - rc_q[1], 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter that shares one `pipelined_multiplier_4x4_final` instance (4x4 unsigned, fixed latency, no stall) among `NREQ` requesters. Accepts at most one operand pair per cycle through valid/ready handshakes and drives the multiplier operand ports. Tracks each in-flight operation's owner in a tag pipeline matched to the multiplier latency. Returns every product on a single tagged response bus.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `MUL_LATENCY`, 4: multiplier latency. An operand pair sampled at edge k gives a valid `mul_product` after edge k+MUL_LATENCY-1.
- `IDW`, `$clog2(NREQ)`: requester ID width (localparam).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`  in  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot grant (combinational); transfer on `req_valid[i] & req_ready[i]`.
- `mul_a`  out  4  operand A to the multiplier.
- `mul_b`  out  4  operand B to the multiplier.
- `mul_product`  in  8  product from the multiplier.
- `rsp_valid`  out  1  response valid for one cycle.
- `rsp_id`  out  IDW  requester that owns the response.
- `rsp_product`  out  8  product (= `mul_product` when `rsp_valid`).
- `busy`  out  1  at least one operation is in flight.

## Operation
- Round-robin pointer `last` (IDW bits) holds the last granted ID. Search priority starts at `last+1` and wraps modulo NREQ.
- `req_ready` is one-hot: the first requester in priority order with `req_valid` high. It is all-zero when no requester is valid. Never more than one bit is high.
- Grant is purely combinational from `req_valid` and `last`. `req_ready[i]` may rise in the same cycle `req_valid[i]` rises.
- On acceptance, `last` is set to the granted ID at the clock edge. With no acceptance, `last` holds.
- A requester must hold `req_valid` and its operands stable until accepted. A requester that is not granted sees `req_ready[i]=0` and is not sampled.
- `mul_a`/`mul_b` are muxed from the granted requester's operands. When there is no grant they are 4'd0 (a bubble).
- Tag pipeline has MUL_LATENCY stages, each {valid, id}.
  - Stage 0 loads {accept, granted ID} every edge.
  - Each stage j loads from stage j-1 every edge; the pipeline never stalls.
- Responses:
  - `rsp_valid` = last-stage valid; `rsp_id` = last-stage id.
  - `rsp_product` = `mul_product` when `rsp_valid`, else 8'd0.
- `busy` = OR of all stage valids.
- Arithmetic is 4x4 unsigned to 8-bit. Maximum product is 225; overflow cannot occur.
- The response bus has no backpressure. Consumers must take `rsp_*` in the cycle it is valid.
- The same requester may issue again while its earlier operations are in flight. Responses return in acceptance order.

## Timing
- Reset (async assert, synchronous-release usage assumed upstream):
  - `last` = NREQ-1, so requester 0 has top priority after reset.
  - All tag valids = 0 and all tag ids = 0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `busy`=0.
  - `req_ready` follows `req_valid` combinationally, even during reset. The block ignores acceptance while `rst_n`=0: it does not load the tag pipeline or `last`.
- Latency: a request accepted at edge k produces `rsp_valid`=1 in the cycle after edge k+MUL_LATENCY-1, for exactly one cycle.
- Throughput: one accept per cycle, sustained. There are no dead cycles between grants to different requesters.
- If `rst_n` asserts while operations are in flight, all of them are dropped. No `rsp_valid` appears for them after release, even though the multiplier itself is not reset.
- Simultaneous accept and retire in one cycle is normal pipeline behaviour; `busy` stays 1.
- Wrap-around: after granting NREQ-1, priority order restarts at 0.

## Test plan
- Single request: reset, then requester 0 offers a=3, b=5 -> `req_ready[0]`=1 that cycle. MUL_LATENCY-1 edges after acceptance: `rsp_valid`=1, `rsp_id`=0, `rsp_product`=15. `busy` falls the following cycle.
- All four requesters valid from reset with (3,5), (7,2), (8,9), (15,15) -> grants 0,1,2,3 on consecutive edges. Responses follow on consecutive cycles: 15/id0, 14/id1, 72/id2, 225/id3.
- Fairness: requesters 1 and 3 held valid continuously -> grants alternate 1,3,1,3. Neither requester waits more than one cycle.
- Hold: requester 2 valid with (6,4) while requester 1 is granted -> requester 2's operands stay unsampled until `req_ready[2]` is 1. Its response is 24 with id 2.
- Reset mid-flight: accept two ops, assert `rst_n`=0 one cycle later, release -> no `rsp_valid` ever appears. Outputs stay 0 and the next grant goes to requester 0 first.
- Bubbles: requests on alternate cycles -> `mul_a`/`mul_b`=0 in idle cycles and `rsp_valid` pulses alternate one-for-one with the requests.
